// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: AXI4 read-channel bundle (AR + R), N packed lanes for the AR fields and per-lane handshakes
// Ports: none; signals arid/araddr/arlen/arsize/arburst/arvalid/arready per lane, rid/rdata/rresp/rlast broadcast,
//   rvalid/rready per lane; modport master drives AR and rready, modport slave drives arready and R
interface axi_rd_arbiter_if #(
  parameter int N = 1,
  parameter int ID_WIDTH = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [N*ID_WIDTH-1:0]   arid;
  logic [N*ADDR_WIDTH-1:0] araddr;
  logic [N*8-1:0]          arlen;
  logic [N*3-1:0]          arsize;
  logic [N*2-1:0]          arburst;
  logic [N-1:0]            arvalid;
  logic [N-1:0]            arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [N-1:0]            rvalid;
  logic [N-1:0]            rready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin arbiter sharing one AXI4 read port (AR + R) between NUM_M read masters
// Ports: clk; reset_n async active-low; m = per-master read bus (N=NUM_M, master i at slice i);
//   s = shared read bus to the memory slave (N=1); grant = one-hot owner (0 when idle);
//   err = sticky RLAST / beat-count mismatch
module axi_rd_arbiter #(
  parameter int NUM_M = 2,
  parameter int ID_WIDTH = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  axi_rd_arbiter_if.slave  m,
  axi_rd_arbiter_if.master s,
  output logic [NUM_M-1:0] grant,
  output logic             err
);
  localparam int PW = $clog2(NUM_M);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t        state;
  logic [PW-1:0] rr_ptr, g, sel, idx;
  logic [7:0]    beat_cnt;
  logic          beat;
  // Scan downward so the last hit is the nearest requester above rr_ptr.
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = NUM_M; k >= 1; k--) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_M);
      if (m.arvalid[idx]) sel = idx;
    end
  end
  assign beat      = state == DATA && s.rvalid[0] && s.rready[0];
  assign s.arid    = m.arid[int'(g)*ID_WIDTH +: ID_WIDTH];
  assign s.araddr  = m.araddr[int'(g)*ADDR_WIDTH +: ADDR_WIDTH];
  assign s.arlen   = m.arlen[int'(g)*8 +: 8];
  assign s.arsize  = m.arsize[int'(g)*3 +: 3];
  assign s.arburst = m.arburst[int'(g)*2 +: 2];
  assign s.arvalid = state == ADDR;
  assign s.rready  = state == DATA ? m.rready[g] : 1'b0;
  assign m.arready = state == ADDR ? grant & {NUM_M{s.arready[0]}} : '0;
  assign m.rvalid  = state == DATA ? grant & {NUM_M{s.rvalid[0]}} : '0;
  assign m.rid     = s.rid;
  assign m.rdata   = s.rdata[DATA_WIDTH-1:0];
  assign m.rresp   = s.rresp;
  assign m.rlast   = s.rlast;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      grant    <= '0;
      g        <= '0;
      rr_ptr   <= PW'(NUM_M - 1);
      beat_cnt <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|m.arvalid) begin
          g        <= sel;
          grant    <= NUM_M'(1) << sel;
          beat_cnt <= m.arlen[int'(sel)*8 +: 8];
          state    <= ADDR;
        end
        ADDR: if (s.arready[0]) state <= DATA;
        DATA: if (beat) begin
          // RLAST always ends the burst; a count mismatch only raises err.
          if (s.rlast) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= g;
            if (beat_cnt != 8'd0) err <= 1'b1;
          end else if (beat_cnt == 8'd0) err <= 1'b1;
          else beat_cnt <= beat_cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed self-checking bench for axi_rd_arbiter with two masters
module tb_axi_rd_arbiter;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] grant;
  logic       err;
  int         checks = 0;
  int         errors = 0;
  int         nacc;
  axi_rd_arbiter_if #(.N(2)) m();
  axi_rd_arbiter_if #(.N(1)) s();
  axi_rd_arbiter dut (
    .clk(clk),
    .reset_n(reset_n),
    .m(m),
    .s(s),
    .grant(grant),
    .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input int mi, input logic [31:0] a, input logic [7:0] l);
    m.arid[mi*3 +: 3]    = 3'(mi + 1);
    m.araddr[mi*32 +: 32] = a;
    m.arlen[mi*8 +: 8]    = l;
    m.arsize[mi*3 +: 3]   = 3'd3;
    m.arburst[mi*2 +: 2]  = 2'd1;
    m.arvalid[mi]         = 1'b1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask
  // Expects ADDR with owner eg; completes the AR handshake, optionally retiring the request.
  task automatic addr_hs(input logic [1:0] eg, input logic [31:0] ea, input logic [2:0] eid,
                         input logic [7:0] el, input bit drop);
    #1;
    chk("s_arvalid", 64'(s.arvalid), 1);
    chk("grant", 64'(grant), 64'(eg));
    chk("s_araddr", 64'(s.araddr), 64'(ea));
    chk("s_arid", 64'(s.arid), 64'(eid));
    chk("s_arlen", 64'(s.arlen), 64'(el));
    chk("s_arsize", 64'(s.arsize), 3);
    chk("m_arready_lo", 64'(m.arready), 0);
    s.arready = 1'b1;
    #1;
    chk("m_arready", 64'(m.arready), 64'(eg));
    cyc();
    s.arready = 1'b0;
    if (drop) m.arvalid = m.arvalid & ~eg;
  endtask
  task automatic beats(input logic [1:0] eg, input int n, input bit last);
    for (int b = 0; b < n; b++) begin
      s.rvalid = 1'b1;
      s.rdata  = 64'hD00000 + 64'(b);
      s.rid    = 3'(b);
      s.rresp  = 2'd0;
      s.rlast  = last && b == n - 1;
      #1;
      chk("m_rvalid", 64'(m.rvalid), 64'(eg));
      chk("s_rready", 64'(s.rready), 1);
      chk("m_rdata", 64'(m.rdata), 64'hD00000 + 64'(b));
      chk("m_rlast", 64'(m.rlast), 64'(last && b == n - 1));
      cyc();
    end
    s.rvalid = 1'b0;
    s.rlast  = 1'b0;
  endtask
  initial begin
    m.arid = '0; m.araddr = '0; m.arlen = '0; m.arsize = '0; m.arburst = '0;
    m.arvalid = '0; m.rready = '0;
    s.arready = '0; s.rid = '0; s.rdata = '0; s.rresp = '0; s.rlast = 1'b0; s.rvalid = '0;
    #2;
    chk("rst_grant", 64'(grant), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_s_arvalid", 64'(s.arvalid), 0);
    chk("rst_m_arready", 64'(m.arready), 0);
    chk("rst_m_rvalid", 64'(m.rvalid), 0);
    chk("rst_s_rready", 64'(s.rready), 0);
    #10 reset_n = 1'b1;
    cyc();
    // single master, 8-beat burst
    req(0, 32'hFC0, 8'd7);
    m.rready = 2'b11;
    #1;
    chk("t1_latency", 64'(s.arvalid), 0);
    cyc();
    addr_hs(2'b01, 32'hFC0, 3'd1, 8'd7, 1'b1);
    beats(2'b01, 8, 1'b1);
    #1;
    chk("t1_idle_grant", 64'(grant), 0);
    chk("t1_err", 64'(err), 0);
    s.rvalid = 1'b1;
    #1;
    chk("t1_stray_rready", 64'(s.rready), 0);
    chk("t1_stray_rvalid", 64'(m.rvalid), 0);
    s.rvalid = 1'b0;
    // two continuous requesters alternate; one idle cycle between bursts
    do_reset();
    req(0, 32'h1000, 8'd3);
    req(1, 32'h2000, 8'd3);
    cyc();
    for (int r = 0; r < 4; r++) begin
      if (r % 2 == 0) begin
        addr_hs(2'b01, 32'h1000, 3'd1, 8'd3, r >= 2);
        beats(2'b01, 4, 1'b1);
      end else begin
        addr_hs(2'b10, 32'h2000, 3'd2, 8'd3, r >= 2);
        beats(2'b10, 4, 1'b1);
      end
      #1;
      chk("t2_gap", 64'(s.arvalid), 0);
      if (r < 3) cyc();
    end
    cyc();
    chk("t2_idle", 64'(grant), 0);
    // slave stalls arready for five cycles
    req(1, 32'h3000, 8'd0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("t3_araddr", 64'(s.araddr), 'h3000);
      chk("t3_arready", 64'(m.arready), 0);
      cyc();
    end
    addr_hs(2'b10, 32'h3000, 3'd2, 8'd0, 1'b1);
    beats(2'b10, 1, 1'b1);
    // master backpressure on a 2-beat burst
    req(0, 32'h4000, 8'd1);
    cyc();
    addr_hs(2'b01, 32'h4000, 3'd1, 8'd1, 1'b1);
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      m.rready = (i % 2 == 0) ? 2'b11 : 2'b10;
      s.rvalid = 1'b1;
      s.rdata  = 64'hA0 + 64'(nacc);
      s.rlast  = nacc == 1;
      #1;
      chk("t4_s_rready", 64'(s.rready), (i % 2 == 0 && i < 3) ? 1 : 0);
      if (s.rvalid && s.rready) begin
        chk("t4_rdata", 64'(m.rdata), 64'hA0 + 64'(nacc));
        nacc++;
      end
      cyc();
    end
    s.rvalid = 1'b0;
    s.rlast  = 1'b0;
    m.rready = 2'b11;
    chk("t4_beats", 64'(nacc), 2);
    chk("t4_err", 64'(err), 0);
    chk("t4_grant", 64'(grant), 0);
    // early RLAST on beat 3 of an 8-beat burst, then master 1 served
    req(0, 32'h5000, 8'd7);
    cyc();
    req(1, 32'h6000, 8'd0);
    addr_hs(2'b01, 32'h5000, 3'd1, 8'd7, 1'b1);
    beats(2'b01, 4, 1'b1);
    #1;
    chk("t5_err", 64'(err), 1);
    chk("t5_grant", 64'(grant), 0);
    cyc();
    addr_hs(2'b10, 32'h6000, 3'd2, 8'd0, 1'b1);
    beats(2'b10, 1, 1'b1);
    chk("t5_err_sticky", 64'(err), 1);
    // reset in the middle of a burst
    req(0, 32'h8000, 8'd7);
    cyc();
    addr_hs(2'b01, 32'h8000, 3'd1, 8'd7, 1'b1);
    beats(2'b01, 4, 1'b0);
    s.rvalid = 1'b1;
    #1;
    chk("t6_pre_rvalid", 64'(m.rvalid), 1);
    reset_n = 1'b0;
    #1;
    chk("t6_m_rvalid", 64'(m.rvalid), 0);
    chk("t6_s_rready", 64'(s.rready), 0);
    chk("t6_s_arvalid", 64'(s.arvalid), 0);
    chk("t6_m_arready", 64'(m.arready), 0);
    chk("t6_grant", 64'(grant), 0);
    chk("t6_err", 64'(err), 0);
    s.rvalid = 1'b0;
    req(1, 32'h9000, 8'd0);
    req(0, 32'hA000, 8'd0);
    cyc();
    reset_n = 1'b1;
    cyc();
    addr_hs(2'b01, 32'hA000, 3'd1, 8'd0, 1'b1);
    beats(2'b01, 1, 1'b1);
    // extra beat past ARLEN before RLAST
    cyc();
    addr_hs(2'b10, 32'h9000, 3'd2, 8'd0, 1'b1);
    beats(2'b10, 2, 1'b1);
    #1;
    chk("t7_err", 64'(err), 1);
    chk("t7_grant", 64'(grant), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
